// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
//   Shared defaults and the bus-owner encoding for the data-memory arbiter.
//   Contents:
//     DEF_DATA_W / DEF_ADDR_W / DEF_MEM_DEPTH : parameter defaults for the top
//     owner_e                                 : lock owner (NONE / M0 / M1)
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_MEM_DEPTH = 256;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_rr_pick.sv
// -----------------------------------------------------------------------------
// dmem_rr_pick
//   Two-way grant picker: a locked owner keeps the bus while it keeps
//   requesting; otherwise a single requester wins, and on contention the
//   master that was not granted last wins.
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     req_i    in   [1:0] per-master request
//     lock_i   in   [1:0] per-master lock (only honoured for the granted master)
//     gnt_o    out  [1:0] one-hot (or zero) grant, combinational from req_i
// -----------------------------------------------------------------------------
module dmem_rr_pick
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  output logic [1:0] gnt_o
);

  owner_e     owner_q, owner_d;
  logic       last_gnt_q, last_gnt_d;  // index of the most recently granted master
  logic [1:0] pick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= OWN_NONE;
      last_gnt_q <= 1'b1;  // so master 0 wins the first contention
    end else begin
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  always_comb begin
    pick       = 2'b00;
    owner_d    = OWN_NONE;
    last_gnt_d = last_gnt_q;

    if (owner_q == OWN_M0 && req_i[0]) begin
      pick = 2'b01;
    end else if (owner_q == OWN_M1 && req_i[1]) begin
      pick = 2'b10;
    end else if (req_i == 2'b11) begin
      pick = last_gnt_q ? 2'b01 : 2'b10;
    end else begin
      pick = req_i;
    end

    if (|pick) begin
      last_gnt_d = pick[1];
    end

    // Ownership only follows a grant; an ungranted lock is ignored and any
    // cycle without the owner's req+lock falls back to NONE.
    if (pick[0] && lock_i[0]) begin
      owner_d = OWN_M0;
    end else if (pick[1] && lock_i[1]) begin
      owner_d = OWN_M1;
    end

    // Reset must kill the grant combinationally, not just at the next edge.
    gnt_o = rst_n ? pick : 2'b00;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory (combinational read, clocked write)
//   between master 0 (CPU load/store) and master 1 (loader/debug/DMA).
//   Out-of-range accesses are granted but never reach memory; every grant
//   produces a registered response one cycle later.
//   Ports:
//     clk, rst_n                      clock, asynchronous active-low reset
//     mX_req/we/lock/addr/wdata  in   master X request channel
//     mX_gnt                     out  master X accepted this cycle
//     mX_rvalid/rdata/err        out  master X response (one cycle after gnt)
//     mem_address/write/wdata    out  memory drive for the granted master
//     mem_rdata                  in   memory read data
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] DEPTH_LIM = ADDR_W'(MEM_DEPTH);

  logic [1:0]        gnt;
  logic              any_gnt;
  logic              sel;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;
  logic              in_range;

  logic [1:0]        rvalid_arr;
  logic [1:0]        err_arr;
  logic [DATA_W-1:0] rdata_arr [2];

  dmem_rr_pick u_pick (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  ({m1_req, m0_req}),
    .lock_i ({m1_lock, m0_lock}),
    .gnt_o  (gnt)
  );

  assign m0_gnt  = gnt[0];
  assign m1_gnt  = gnt[1];
  assign any_gnt = |gnt;
  assign sel     = gnt[1];

  assign sel_addr  = sel ? m1_addr  : m0_addr;
  assign sel_wdata = sel ? m1_wdata : m0_wdata;
  assign sel_we    = sel ? m1_we    : m0_we;
  assign in_range  = (sel_addr < DEPTH_LIM);

  // Idle bus is driven to zero so nothing downstream sees stale addresses.
  assign mem_address = any_gnt ? sel_addr  : '0;
  assign mem_wdata   = any_gnt ? sel_wdata : '0;
  assign mem_write   = any_gnt & sel_we & in_range;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
      logic              rvalid_q, rvalid_d;
      logic              err_q, err_d;
      logic [DATA_W-1:0] rdata_q, rdata_d;

      // gnt[gi] implies sel == gi, so the shared mux outputs belong to this master.
      always_comb begin
        rvalid_d = gnt[gi];
        err_d    = gnt[gi] & ~in_range;
        rdata_d  = (gnt[gi] && !sel_we && in_range) ? mem_rdata : '0;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rvalid_q <= 1'b0;
          err_q    <= 1'b0;
          rdata_q  <= '0;
        end else begin
          rvalid_q <= rvalid_d;
          err_q    <= err_d;
          rdata_q  <= rdata_d;
        end
      end

      assign rvalid_arr[gi] = rvalid_q;
      assign err_arr[gi]    = err_q;
      assign rdata_arr[gi]  = rdata_q;
    end
  endgenerate

  assign m0_rvalid = rvalid_arr[0];
  assign m0_err    = err_arr[0];
  assign m0_rdata  = rdata_arr[0];
  assign m1_rvalid = rvalid_arr[1];
  assign m1_err    = err_arr[1];
  assign m1_rdata  = rdata_arr[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Drives both masters, models the data memory, predicts grants and
//   responses from the arbitration rules, and checks responses in a separate
//   monitor fed by per-master expectation queues.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 256;

  typedef struct packed {
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_address;
  logic          mem_write;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_address(mem_address), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // ---------------- data memory stand-in (combinational read) ---------------
  logic          init_done = 1'b0;
  logic [DW-1:0] bmem [DEPTH];

  function automatic logic [DW-1:0] seed_val(input int i);
    return (i * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign mem_rdata = bmem[mem_address[7:0]];

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < DEPTH; i++) bmem[i] <= seed_val(i);
    end else if (mem_write) begin
      bmem[mem_address[7:0]] <= mem_wdata;
    end
  end

  // ---------------- reference model and scoreboard --------------------------
  logic [DW-1:0] ref_mem [DEPTH];
  int            ref_owner = -1;  // master holding the lock, -1 when none
  int            ref_last  = 1;   // master granted most recently
  resp_t         q0[$];
  resp_t         q1[$];
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic req, input logic we, input logic lock,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    txn_t t;
    t.req = req; t.we = we; t.lock = lock; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  // Apply one cycle of requests at negedge, check the combinational grant and
  // memory drive, and record the expected response for the granted master.
  task automatic drive(input txn_t t0, input txn_t t1, output logic [1:0] g);
    logic [1:0] eg;
    txn_t       w;
    logic       inr;
    resp_t      e;
    int         who;
    @(negedge clk);
    m0_req = t0.req; m0_we = t0.we; m0_lock = t0.lock; m0_addr = t0.addr; m0_wdata = t0.wdata;
    m1_req = t1.req; m1_we = t1.we; m1_lock = t1.lock; m1_addr = t1.addr; m1_wdata = t1.wdata;
    #1;
    if (ref_owner == 0 && t0.req)      eg = 2'b01;
    else if (ref_owner == 1 && t1.req) eg = 2'b10;
    else if (t0.req && t1.req)         eg = (ref_last == 1) ? 2'b01 : 2'b10;
    else                               eg = {t1.req, t0.req};
    chk("m0_gnt", m0_gnt, eg[0]);
    chk("m1_gnt", m1_gnt, eg[1]);
    if (eg != 2'b00) begin
      who = eg[1] ? 1 : 0;
      w   = eg[1] ? t1 : t0;
      inr = (w.addr < DEPTH);
      chk("mem_address", mem_address, w.addr);
      chk("mem_wdata", mem_wdata, w.wdata);
      chk("mem_write", mem_write, w.we && inr);
      e.err   = !inr;
      e.rdata = (!w.we && inr) ? ref_mem[w.addr[7:0]] : '0;
      if (who == 1) q1.push_back(e); else q0.push_back(e);
      if (w.we && inr) ref_mem[w.addr[7:0]] = w.wdata;
      ref_last  = who;
      ref_owner = w.lock ? who : -1;
      $display("[TB] t=%0t m%0d %s addr=0x%0h wdata=0x%0h lock=%0b exp_rdata=0x%0h exp_err=%0b",
               $time, who, w.we ? "WR" : "RD", w.addr, w.wdata, w.lock, e.rdata, e.err);
    end else begin
      chk("idle_mem_address", mem_address, '0);
      chk("idle_mem_write", mem_write, 1'b0);
      ref_owner = -1;
    end
    g = eg;
  endtask

  // Response monitor: one response per grant, exactly one cycle later.
  initial begin
    resp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (m0_rvalid) begin
        if (q0.size() == 0) chk("m0_rvalid_unexpected", m0_rvalid, 1'b0);
        else begin
          e = q0.pop_front();
          chk("m0_rdata", m0_rdata, e.rdata);
          chk("m0_err", m0_err, e.err);
        end
      end else if (q0.size() != 0) begin
        chk("m0_rvalid_missing", m0_rvalid, 1'b1);
        void'(q0.pop_front());
      end
      if (m1_rvalid) begin
        if (q1.size() == 0) chk("m1_rvalid_unexpected", m1_rvalid, 1'b0);
        else begin
          e = q1.pop_front();
          chk("m1_rdata", m1_rdata, e.rdata);
          chk("m1_err", m1_err, e.err);
        end
      end else if (q1.size() != 0) begin
        chk("m1_rvalid_missing", m1_rvalid, 1'b1);
        void'(q1.pop_front());
      end
    end
  end

  // ---------------- stimulus ------------------------------------------------
  txn_t       idle_t;
  txn_t       cur [2];
  logic       pend [2];
  int         burst [2];
  logic [1:0] g;
  int         mism;

  initial begin
    idle_t = mk(1'b0, 1'b0, 1'b0, '0, '0);
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_val(i);
    @(posedge clk);
    #1 init_done = 1'b1;

    // Grants are suppressed while reset is held, even with both masters asking.
    @(negedge clk);
    m0_req = 1; m1_req = 1;
    #1;
    chk("rst_m0_gnt", m0_gnt, 1'b0);
    chk("rst_m1_gnt", m1_gnt, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    m0_req = 0; m1_req = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_m0_rvalid", m0_rvalid, 1'b0);
    chk("post_rst_m1_rvalid", m1_rvalid, 1'b0);
    chk("post_rst_m0_rdata", m0_rdata, '0);
    chk("post_rst_m1_rdata", m1_rdata, '0);
    chk("post_rst_m0_err", m0_err, 1'b0);
    chk("post_rst_m1_err", m1_err, 1'b0);
    chk("post_rst_mem_address", mem_address, '0);

    // Continuous contention: alternation starting with master 0.
    for (int k = 0; k < 6; k++)
      drive(mk(1, 0, 0, AW'($urandom_range(0, 255)), '0),
            mk(1, 0, 0, AW'($urandom_range(0, 255)), '0), g);

    // Write then read the same address back-to-back.
    drive(mk(1, 1, 0, 5, 32'hDEADBEEF), idle_t, g);
    drive(mk(1, 0, 0, 5, '0), idle_t, g);

    // Locked four-beat write burst from master 1 while master 0 waits.
    for (int k = 0; k < 4; k++)
      drive(mk(1, 0, 0, 20, '0), mk(1, 1, 1, AW'(10 + k), $urandom), g);
    drive(mk(1, 0, 0, 20, '0), idle_t, g);
    for (int k = 0; k < 4; k++)
      drive(mk(1, 0, 0, AW'(10 + k), '0), idle_t, g);

    // Out-of-range write: granted, never reaches memory, error response.
    drive(mk(1, 1, 0, 300, 32'h1), idle_t, g);
    drive(idle_t, idle_t, g);
    chk("oor_mem44_unchanged", bmem[44], ref_mem[44]);

    // Reset in the middle of a master 1 write.
    drive(idle_t, idle_t, g);
    @(negedge clk);
    m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 7; m1_wdata = 32'hCAFE_F00D;
    #1;
    chk("pre_rst_m1_gnt", m1_gnt, 1'b1);
    chk("pre_rst_mem_write", mem_write, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_m1_gnt", m1_gnt, 1'b0);
    chk("mid_rst_m0_gnt", m0_gnt, 1'b0);
    chk("mid_rst_mem_write", mem_write, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
    rst_n = 1'b1;
    ref_owner = -1;
    ref_last  = 1;
    #1;
    chk("rst2_m0_rvalid", m0_rvalid, 1'b0);
    chk("rst2_m1_rvalid", m1_rvalid, 1'b0);
    chk("rst2_m1_err", m1_err, 1'b0);
    chk("rst2_mem7", bmem[7], ref_mem[7]);
    drive(mk(1, 0, 0, 7, '0), mk(1, 0, 0, 8, '0), g);  // next contention goes to M0

    // Randomized traffic with occasional locked bursts and out-of-range hits.
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; burst[m] = 0; cur[m] = idle_t;
    end
    for (int c = 0; c < 1200; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m]) begin
          if (burst[m] > 0 || $urandom_range(0, 9) < 6) begin
            if (burst[m] == 0 && $urandom_range(0, 7) == 0) burst[m] = $urandom_range(2, 4);
            cur[m] = mk(1'b1, 1'($urandom_range(0, 1)), burst[m] > 1,
                        ($urandom_range(0, 9) == 0) ? AW'($urandom_range(256, 1023))
                                                     : AW'($urandom_range(0, 31)),
                        $urandom);
            if (burst[m] > 0) burst[m]--;
            pend[m] = 1'b1;
          end else begin
            cur[m] = idle_t;
          end
        end
      end
      drive(cur[0], cur[1], g);
      if (g[0]) pend[0] = 1'b0;
      if (g[1]) pend[1] = 1'b0;
    end

    drive(idle_t, idle_t, g);
    drive(idle_t, idle_t, g);
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (bmem[i] !== ref_mem[i]) mism++;
    chk("final_mem_mismatches", mism, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
